// File: rtl/capture_pkg.sv
// ---------------------------------------------------------------------------
// capture_pkg
// Shared definitions for the ADC capture write path.
//   CAP_DATA_W    : default ADC sample width (one bit per ADC data pad)
//   CAP_MEM_DEPTH : default capture memory depth in words
//   cap_state_t   : capture controller state encoding
// ---------------------------------------------------------------------------
package capture_pkg;

  localparam int CAP_DATA_W    = 18;
  localparam int CAP_MEM_DEPTH = 4096;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_FILL = 2'd1,
    CAP_DONE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/cap_edge_det.sv
// ---------------------------------------------------------------------------
// cap_edge_det
// Registered rising-edge detector for a regfile level signal.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   i_level : level input from the register file
//   o_rise  : one-cycle registered pulse when i_level goes 0 -> 1
// ---------------------------------------------------------------------------
module cap_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;
  logic r_armed;
  logic r_rise;

  // The previous level is tracked every cycle. r_armed stays low for the
  // first clock after reset so that a level already high during reset is
  // absorbed into r_prev instead of being reported as a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_prev  <= i_level;
      r_armed <= 1'b1;
      r_rise  <= r_armed & i_level & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/capture_wr_ctrl.sv
// ---------------------------------------------------------------------------
// capture_wr_ctrl
// Fills the capture memory with MEM_DEPTH consecutive ADC samples (or a ramp
// in self-test mode) after a start request, then signals the readout side.
// Ports:
//   clk, rst           : clock and asynchronous active-high reset
//   cfg_capture_start  : start level, rising edge starts a capture
//   cfg_capture_again  : re-capture level, rising edge refills from DONE
//   cfg_capture_mode   : 1 freezes the fill (writes paused), 0 normal
//   cfg_self_test_mode : 1 writes the ramp pattern instead of ADC data
//   adc_data_i         : ADC sample
//   adc_valid_i        : adc_data_i valid this cycle
//   mem_wr_en/addr/data: registered memory write port
//   cap_busy, cap_done : high in FILL / DONE
//   rd_start           : one-cycle pulse issued with the last write
// ---------------------------------------------------------------------------
module capture_wr_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_W    = CAP_DATA_W,
  parameter int MEM_DEPTH = CAP_MEM_DEPTH,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_capture_start,
  input  logic              cfg_capture_again,
  input  logic              cfg_capture_mode,
  input  logic              cfg_self_test_mode,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              adc_valid_i,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              rd_start
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  cap_state_t        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_ramp;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_start;

  logic w_start_rise;
  logic w_again_rise;
  logic w_qualify;

  cap_edge_det u_start_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (cfg_capture_start),
    .o_rise  (w_start_rise)
  );

  cap_edge_det u_again_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (cfg_capture_again),
    .o_rise  (w_again_rise)
  );

  // A sample is taken when not frozen and either the ADC has data or the
  // ramp generator is the source (the ramp never needs a valid strobe).
  assign w_qualify = ~cfg_capture_mode & (adc_valid_i | cfg_self_test_mode);

  // Capture FSM with all outputs registered. Write strobe and rd_start
  // default low each cycle; the last write leaves FILL in the same cycle so
  // the counter stops at MEM_DEPTH-1 rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CAP_IDLE;
      r_cnt      <= '0;
      r_ramp     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_start <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_rd_start <= 1'b0;
      case (r_state)
        CAP_IDLE: begin
          if (w_start_rise) begin
            r_state <= CAP_FILL;
            r_cnt   <= '0;
            r_ramp  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        CAP_FILL: begin
          if (w_qualify) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_cnt;
            r_wr_data <= cfg_self_test_mode ? r_ramp : adc_data_i;
            r_ramp    <= r_ramp + DATA_W'(1);
            if (r_cnt == LAST_ADDR) begin
              r_state    <= CAP_DONE;
              r_rd_start <= 1'b1;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_cnt <= r_cnt + ADDR_W'(1);
            end
          end
        end
        CAP_DONE: begin
          if (w_start_rise | w_again_rise) begin
            r_state <= CAP_FILL;
            r_cnt   <= '0;
            r_ramp  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= CAP_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;
  assign cap_busy    = r_busy;
  assign cap_done    = r_done;
  assign rd_start    = r_rd_start;

endmodule

// File: tb/tb_capture_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_capture_wr_ctrl
// Directed bench for capture_wr_ctrl with MEM_DEPTH=16, DATA_W=18.
// ---------------------------------------------------------------------------
module tb_capture_wr_ctrl;

  localparam int DATA_W    = 18;
  localparam int MEM_DEPTH = 16;
  localparam int ADDR_W    = 4;

  logic              clk;
  logic              rst;
  logic              cfg_capture_start;
  logic              cfg_capture_again;
  logic              cfg_capture_mode;
  logic              cfg_self_test_mode;
  logic [DATA_W-1:0] adc_data_i;
  logic              adc_valid_i;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              cap_busy;
  logic              cap_done;
  logic              rd_start;

  int vectors;
  int miscompares;
  int cycleCount;

  logic [ADDR_W-1:0] addrQ[$];
  logic [DATA_W-1:0] dataQ[$];
  int                stampQ[$];
  int                rdCount;
  logic [ADDR_W-1:0] rdAddr;

  capture_wr_ctrl #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_capture_start  (cfg_capture_start),
    .cfg_capture_again  (cfg_capture_again),
    .cfg_capture_mode   (cfg_capture_mode),
    .cfg_self_test_mode (cfg_self_test_mode),
    .adc_data_i         (adc_data_i),
    .adc_valid_i        (adc_valid_i),
    .mem_wr_en          (mem_wr_en),
    .mem_wr_addr        (mem_wr_addr),
    .mem_wr_data        (mem_wr_data),
    .cap_busy           (cap_busy),
    .cap_done           (cap_done),
    .rd_start           (rd_start)
  );

  // 10 ns clock; stimulus changes on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write logger: samples 1 ns after each rising edge and records every
  // write with its cycle stamp, plus where rd_start appeared.
  initial cycleCount = 0;
  always @(posedge clk) begin
    cycleCount = cycleCount + 1;
    #1;
    if (!rst && mem_wr_en) begin
      addrQ.push_back(mem_wr_addr);
      dataQ.push_back(mem_wr_data);
      stampQ.push_back(cycleCount);
    end
    if (!rst && rd_start) begin
      rdCount = rdCount + 1;
      rdAddr  = mem_wr_addr;
    end
  end

  // One comparison: count it, and report it when it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic clearLog();
    addrQ.delete();
    dataQ.delete();
    stampQ.delete();
    rdCount = 0;
    rdAddr  = '0;
  endtask

  // Pulse one or both request levels for one cycle, then wait the cycle
  // the edge detector needs, leaving the DUT in FILL at the next negedge.
  task automatic applyStimulus(input logic startLvl, input logic againLvl);
    cfg_capture_start = startLvl;
    cfg_capture_again = againLvl;
    tick(1);
    cfg_capture_start = 1'b0;
    cfg_capture_again = 1'b0;
    tick(1);
  endtask

  // Checks a completed capture: 16 writes, addresses 0..15, data base+i,
  // one rd_start issued alongside address 15, and DONE status.
  task automatic verifyFill(input string name, input logic [31:0] base);
    logic [31:0] obsA;
    logic [31:0] obsD;
    checkOutput({name, "_count"}, addrQ.size(), 32'd16);
    for (int i = 0; i < 16; i++) begin
      obsA = (i < addrQ.size()) ? 32'(addrQ[i]) : 32'hDEAD_BEEF;
      obsD = (i < dataQ.size()) ? 32'(dataQ[i]) : 32'hDEAD_BEEF;
      checkOutput($sformatf("%s_addr%0d", name, i), obsA, 32'(i));
      checkOutput($sformatf("%s_data%0d", name, i), obsD, base + 32'(i));
    end
    checkOutput({name, "_rdcount"}, rdCount, 32'd1);
    checkOutput({name, "_rdaddr"}, 32'(rdAddr), 32'd15);
    checkOutput({name, "_done"}, 32'(cap_done), 32'd1);
    checkOutput({name, "_busy"}, 32'(cap_busy), 32'd0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    checkOutput({name, "_wr_addr"}, 32'(mem_wr_addr), 32'd0);
    checkOutput({name, "_wr_data"}, 32'(mem_wr_data), 32'd0);
    checkOutput({name, "_busy"}, 32'(cap_busy), 32'd0);
    checkOutput({name, "_done"}, 32'(cap_done), 32'd0);
    checkOutput({name, "_rd_start"}, 32'(rd_start), 32'd0);
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    rst                = 1'b1;
    cfg_capture_start  = 1'b1;
    cfg_capture_again  = 1'b0;
    cfg_capture_mode   = 1'b0;
    cfg_self_test_mode = 1'b0;
    adc_data_i         = '0;
    adc_valid_i        = 1'b0;
    clearLog();

    // Reset with start already high: outputs at zero and no edge seen later.
    tick(3);
    checkResetValues("reset");
    rst = 1'b0;
    adc_valid_i = 1'b1;
    tick(6);
    checkOutput("held_start_busy", 32'(cap_busy), 32'd0);
    checkOutput("held_start_writes", addrQ.size(), 32'd0);
    cfg_capture_start = 1'b0;
    adc_valid_i = 1'b0;
    tick(2);

    // Normal fill with data 0x100+n and valid every cycle.
    $display("[TB] normal fill");
    clearLog();
    applyStimulus(1'b1, 1'b0);
    checkOutput("normal_busy_entry", 32'(cap_busy), 32'd1);
    checkOutput("normal_no_early_write", 32'(mem_wr_en), 32'd0);
    for (int n = 0; n < 16; n++) begin
      adc_valid_i = 1'b1;
      adc_data_i  = DATA_W'(32'h100 + n);
      tick(1);
      if (n == 0) begin
        checkOutput("normal_first_wr_en", 32'(mem_wr_en), 32'd1);
        checkOutput("normal_first_addr", 32'(mem_wr_addr), 32'd0);
      end
    end
    adc_valid_i = 1'b0;
    tick(3);
    verifyFill("normal", 32'h100);

    // Gapped valid (every third cycle), refill requested with an again edge.
    $display("[TB] gapped valid");
    clearLog();
    applyStimulus(1'b0, 1'b1);
    for (int c = 0; c < 48; c++) begin
      adc_valid_i = (c % 3 == 0);
      adc_data_i  = DATA_W'(32'h200 + c / 3);
      tick(1);
    end
    adc_valid_i = 1'b0;
    tick(3);
    verifyFill("gapped", 32'h200);

    // Self-test ramp: no valid strobes, ADC data ignored.
    $display("[TB] self test");
    clearLog();
    cfg_self_test_mode = 1'b1;
    adc_data_i = 18'h3FFFF;
    applyStimulus(1'b1, 1'b0);
    tick(20);
    verifyFill("selftest", 32'h0);
    checkOutput("selftest_consecutive",
                (stampQ.size() == 16) ? 32'(stampQ[15] - stampQ[0]) : 32'hDEAD_BEEF, 32'd15);
    cfg_self_test_mode = 1'b0;
    tick(2);

    // Freeze for 10 sample cycles after write 5.
    $display("[TB] freeze");
    clearLog();
    applyStimulus(1'b0, 1'b1);
    begin
      int n;
      n = 0;
      for (int c = 0; c < 26; c++) begin
        cfg_capture_mode = (c >= 6 && c < 16);
        adc_valid_i = 1'b1;
        adc_data_i  = DATA_W'(32'h300 + n);
        tick(1);
        if (!cfg_capture_mode) n = n + 1;
      end
    end
    cfg_capture_mode = 1'b0;
    adc_valid_i = 1'b0;
    tick(3);
    verifyFill("freeze", 32'h300);
    checkOutput("freeze_gap",
                (stampQ.size() == 16) ? 32'(stampQ[6] - stampQ[5]) : 32'hDEAD_BEEF, 32'd11);

    // Start and again together in DONE, then both pulsed again inside FILL.
    $display("[TB] simultaneous restart");
    clearLog();
    applyStimulus(1'b1, 1'b1);
    for (int c = 0; c < 16; c++) begin
      cfg_capture_again = (c == 5);
      cfg_capture_start = (c == 8);
      adc_valid_i = 1'b1;
      adc_data_i  = DATA_W'(32'h400 + c);
      tick(1);
    end
    cfg_capture_again = 1'b0;
    cfg_capture_start = 1'b0;
    adc_valid_i = 1'b0;
    tick(3);
    verifyFill("simul", 32'h400);

    // Reset after write 7, then again edge in IDLE, then a fresh start.
    $display("[TB] reset mid-fill");
    clearLog();
    applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      adc_valid_i = 1'b1;
      adc_data_i  = DATA_W'(32'h500 + c);
      tick(1);
    end
    rst = 1'b1;
    #1;
    checkResetValues("midreset");
    checkOutput("midreset_writes", addrQ.size(), 32'd8);
    tick(2);
    clearLog();
    rst = 1'b0;
    tick(20);
    checkOutput("after_reset_writes", addrQ.size(), 32'd0);
    checkOutput("after_reset_busy", 32'(cap_busy), 32'd0);
    applyStimulus(1'b0, 1'b1);
    tick(10);
    checkOutput("again_idle_writes", addrQ.size(), 32'd0);
    checkOutput("again_idle_busy", 32'(cap_busy), 32'd0);
    checkOutput("again_idle_done", 32'(cap_done), 32'd0);
    applyStimulus(1'b1, 1'b0);
    for (int n = 0; n < 16; n++) begin
      adc_valid_i = 1'b1;
      adc_data_i  = DATA_W'(32'h600 + n);
      tick(1);
    end
    adc_valid_i = 1'b0;
    tick(3);
    verifyFill("refill", 32'h600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/capture_wr_ctrl.md
CAPTURE_WR_CTRL -- requirements
Module: capture_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 18, meaning ADC sample width (one bit per ADC data pad).
REQ-002 SHALL have parameter MEM_DEPTH, default 4096, meaning capture memory depth in words (power of two, >=4).
REQ-003 SHALL have parameter ADDR_W, default $clog2(MEM_DEPTH), meaning memory address width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_capture_start  input  1  regfile start level; a rising edge requests a capture.
REQ-007 SHALL have port cfg_capture_again  input  1  regfile re-capture level; a rising edge requests a refill from DONE.
REQ-008 SHALL have port cfg_capture_mode  input  1  1 = freeze (MDIO readback); 0 = normal.
REQ-009 SHALL have port cfg_self_test_mode  input  1  1 = write ramp pattern instead of ADC data.
REQ-010 SHALL have port adc_data_i  input  DATA_W  ADC sample.
REQ-011 SHALL have port adc_valid_i  input  1  adc_data_i is valid this cycle.
REQ-012 SHALL have port mem_wr_en  output  1  memory write strobe.
REQ-013 SHALL have port mem_wr_addr  output  ADDR_W  memory write address.
REQ-014 SHALL have port mem_wr_data  output  DATA_W  memory write data.
REQ-015 SHALL have port cap_busy  output  1  high while in FILL.
REQ-016 SHALL have port cap_done  output  1  high while in DONE.
REQ-017 SHALL have port rd_start  output  1  one-cycle pulse telling package_ctrl the memory is full.

Function
REQ-018 SHALL implement states IDLE, FILL, DONE.
REQ-019 SHALL register cfg_capture_start and cfg_capture_again and detect rising edges (0 in previous cycle, 1 in current).
REQ-020 SHALL go IDLE->FILL on a start edge, clearing the write counter and ramp to 0.
REQ-021 SHALL ignore start and again edges while in FILL.
REQ-022 SHALL go DONE->FILL on an again or start edge, clearing the counter and ramp; both edges in the same cycle count as one restart.
REQ-023 SHALL ignore again edges in IDLE.
REQ-024 SHALL qualify a write in FILL when cfg_capture_mode=0 and (adc_valid_i=1 or cfg_self_test_mode=1).
REQ-025 SHALL, for each qualified cycle, drive mem_wr_en=1 on the next cycle with mem_wr_addr=counter value and mem_wr_data=adc_data_i (or ramp), all registered.
REQ-026 SHALL make the ramp equal to the write index zero-extended/truncated to DATA_W, incrementing once per qualified write.
REQ-027 SHALL hold the counter, ramp and state while cfg_capture_mode=1 in FILL, with mem_wr_en=0.
REQ-028 SHALL go FILL->DONE in the cycle that issues the write to address MEM_DEPTH-1, asserting rd_start for exactly that cycle; the counter never wraps inside FILL.
REQ-029 SHALL issue exactly MEM_DEPTH writes per capture, at addresses 0..MEM_DEPTH-1 in order.
REQ-030 SHALL, with a start edge on the first cycle, produce the first mem_wr_en two cycles after the edge (one cycle edge detect, one cycle registered write).
REQ-031 SHALL drive mem_wr_en=0 in IDLE and DONE.

Reset
REQ-032 SHALL on rst drive state IDLE, counter 0, ramp 0, edge registers 0, mem_wr_en 0, mem_wr_addr 0, mem_wr_data 0, cap_busy 0, cap_done 0, rd_start 0.
REQ-033 SHALL abort a capture on reset mid-FILL with no further write, and stay in IDLE after release until a new start edge.
REQ-034 SHALL not detect a start edge on the first cycle after reset release when cfg_capture_start was already 1 during reset.

Structure
REQ-035 SHALL take the state enum (cap_state_t) and default DATA_W/MEM_DEPTH constants from a shared package, capture_pkg.
REQ-036 SHALL implement edge detection in one sub-module, cap_edge_det, instanced twice; everything else stays in one module.

Verification
REQ-037 SHALL cover a normal fill: MEM_DEPTH=16, start pulse, adc_valid_i=1 continuously, data=0x100+n -> 16 writes at addresses 0..15 with data 0x100..0x10F, one rd_start, cap_done=1.
REQ-038 SHALL cover gapped valid: valid every 3rd cycle -> still exactly 16 writes, addresses contiguous, rd_start after write 15.
REQ-039 SHALL cover self-test: cfg_self_test_mode=1, adc_valid_i=0 -> 16 consecutive writes, data 0..15.
REQ-040 SHALL cover freeze: cfg_capture_mode=1 for 10 cycles after write 5 -> no writes in that window, then resumes at address 6.
REQ-041 SHALL cover again/simultaneous: start and again edges together in DONE -> a single refill from address 0; an again edge in FILL or IDLE -> no effect.
REQ-042 SHALL cover reset mid-fill: rst asserted after write 7 -> all outputs at reset values, no writes until the next start edge, which refills from address 0.
